uarc_receiver_arbiter: RTL and testbench

// - Arbitrates the per-bus UARC receiver requests (kill/incept/send/stream) of core0 onto one message port.
// - Grants one bus per capture and returns its one-hot ack.
// - Registers the winning message for the core datapath behind a valid/ready handshake.
// - Kills take priority; a stream locks the arbiter onto one bus until the stream ends.

---
 rtl/uarc_receiver_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_uarc_receiver_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uarc_receiver_arbiter.sv
// Arbitrates per-bus UARC receiver requests (kill/incept/send/stream) onto a single
// registered message port with valid/ready handshake; kills preempt, streams lock a bus.
module uarc_receiver_arbiter #(
   parameter int  WORD_MAG = 5,
   parameter int  BUSES    = 32,
   localparam int WIDTH    = 1 << WORD_MAG,
   localparam int IDX_W    = $clog2(BUSES)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [BUSES-1:0]                  receiver_enable,
   input  logic [BUSES-1:0]                  receiver_kills,
   input  logic [BUSES-1:0]                  receiver_incepts,
   input  logic [BUSES-1:0]                  receiver_sends,
   input  logic [BUSES-1:0]                  receiver_streams,
   output logic [BUSES-1:0]                  receiver_kill_acks,
   output logic [BUSES-1:0]                  receiver_incept_acks,
   output logic [BUSES-1:0]                  receiver_send_acks,
   output logic [BUSES-1:0]                  receiver_stream_acks,
   input  logic [BUSES-1:0][WIDTH-1:0]       receiver_datas,
   input  logic [BUSES-1:0][WIDTH-1:0]       receiver_self_permissions,
   input  logic [BUSES-1:0][WIDTH-1:0]       receiver_self_addresses,
   input  logic [BUSES-1:0][WIDTH-1:0]       receiver_incept_permissions,
   input  logic [BUSES-1:0][WIDTH-1:0]       receiver_incept_addresses,
   input  logic                              accept,
   output logic                              msg_valid,
   input  logic                              msg_ready,
   output logic [1:0]                        msg_type,
   output logic [IDX_W-1:0]                  msg_bus,
   output logic [WIDTH-1:0]                  msg_data,
   output logic [WIDTH-1:0]                  msg_self_permission,
   output logic [WIDTH-1:0]                  msg_self_address,
   output logic [WIDTH-1:0]                  msg_incept_permission,
   output logic [WIDTH-1:0]                  msg_incept_address,
   output logic                              stream_locked
);

   typedef enum logic [1:0] {
      MSG_KILL   = 2'd0,
      MSG_INCEPT = 2'd1,
      MSG_SEND   = 2'd2,
      MSG_STREAM = 2'd3
   } msg_type_e;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   // First set bit of vec searching upward from ptr+1 with wrap; returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [BUSES-1:0] vec,
                                              input logic [IDX_W-1:0] ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < BUSES; k++) begin
         int j;
         j = int'(ptr) + 1 + k;
         if (j >= BUSES) j = j - BUSES;
         if (!found && vec[IDX_W'(j)]) begin
            found = 1'b1;
            idx   = IDX_W'(j);
         end
      end
      return {found, idx};
   endfunction

   lock_state_e       lock_state_q, lock_state_d;
   logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              msg_valid_q, msg_valid_d;
   msg_type_e         msg_type_q, msg_type_d;
   logic [IDX_W-1:0]  msg_bus_q, msg_bus_d;
   logic [WIDTH-1:0]  msg_data_q, msg_data_d;
   logic [WIDTH-1:0]  msg_self_perm_q, msg_self_perm_d;
   logic [WIDTH-1:0]  msg_self_addr_q, msg_self_addr_d;
   logic [WIDTH-1:0]  msg_incept_perm_q, msg_incept_perm_d;
   logic [WIDTH-1:0]  msg_incept_addr_q, msg_incept_addr_d;

   logic [BUSES-1:0]  req;
   logic [BUSES-1:0]  kill_req;
   logic              cap_ok;
   logic              kill_found, req_found;
   logic [IDX_W-1:0]  kill_idx, req_idx;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   msg_type_e         win_type;
   logic              capture;

   assign kill_req = receiver_enable & receiver_kills;
   assign req      = receiver_enable &
                     (receiver_kills |
                      ({BUSES{accept}} & (receiver_incepts | receiver_sends | receiver_streams)));
   assign cap_ok   = !msg_valid_q || msg_ready;

   assign {kill_found, kill_idx} = rr_pick(kill_req, rr_ptr_q);
   assign {req_found,  req_idx}  = rr_pick(req, rr_ptr_q);

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_type  = MSG_KILL;
      if (kill_found) begin
         win_found = 1'b1;
         win_idx   = kill_idx;
      end else if (lock_state_q == LOCKED) begin
         win_found = req[lock_idx_q];
         win_idx   = lock_idx_q;
      end else begin
         win_found = req_found;
         win_idx   = req_idx;
      end

      if (receiver_kills[win_idx])        win_type = MSG_KILL;
      else if (receiver_incepts[win_idx]) win_type = MSG_INCEPT;
      else if (receiver_sends[win_idx])   win_type = MSG_SEND;
      else                                win_type = MSG_STREAM;
   end

   assign capture = cap_ok && win_found && !reset;

   always_comb begin
      receiver_kill_acks   = '0;
      receiver_incept_acks = '0;
      receiver_send_acks   = '0;
      receiver_stream_acks = '0;
      if (capture) begin
         unique case (win_type)
            MSG_KILL:   receiver_kill_acks[win_idx]   = 1'b1;
            MSG_INCEPT: receiver_incept_acks[win_idx] = 1'b1;
            MSG_SEND:   receiver_send_acks[win_idx]   = 1'b1;
            MSG_STREAM: receiver_stream_acks[win_idx] = 1'b1;
         endcase
      end
   end

   always_comb begin
      msg_valid_d       = msg_valid_q && !msg_ready;
      msg_type_d        = msg_type_q;
      msg_bus_d         = msg_bus_q;
      msg_data_d        = msg_data_q;
      msg_self_perm_d   = msg_self_perm_q;
      msg_self_addr_d   = msg_self_addr_q;
      msg_incept_perm_d = msg_incept_perm_q;
      msg_incept_addr_d = msg_incept_addr_q;
      rr_ptr_d          = rr_ptr_q;
      if (capture) begin
         msg_valid_d       = 1'b1;
         msg_type_d        = win_type;
         msg_bus_d         = win_idx;
         msg_data_d        = receiver_datas[win_idx];
         msg_self_perm_d   = receiver_self_permissions[win_idx];
         msg_self_addr_d   = receiver_self_addresses[win_idx];
         msg_incept_perm_d = receiver_incept_permissions[win_idx];
         msg_incept_addr_d = receiver_incept_addresses[win_idx];
         rr_ptr_d          = win_idx;
      end
   end

   always_comb begin
      lock_state_d = lock_state_q;
      lock_idx_d   = lock_idx_q;
      unique case (lock_state_q)
         UNLOCKED: begin
            if (capture && win_type == MSG_STREAM) begin
               lock_state_d = LOCKED;
               lock_idx_d   = win_idx;
            end
         end
         LOCKED: begin
            if (capture && win_type == MSG_KILL) begin
               lock_state_d = UNLOCKED;
            end else if (cap_ok && (!receiver_enable[lock_idx_q] ||
                                    !receiver_streams[lock_idx_q] || !accept)) begin
               lock_state_d = UNLOCKED;
            end
         end
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_state_q      <= UNLOCKED;
         lock_idx_q        <= '0;
         rr_ptr_q          <= IDX_W'(BUSES - 1);
         msg_valid_q       <= 1'b0;
         msg_type_q        <= MSG_KILL;
         msg_bus_q         <= '0;
         msg_data_q        <= '0;
         msg_self_perm_q   <= '0;
         msg_self_addr_q   <= '0;
         msg_incept_perm_q <= '0;
         msg_incept_addr_q <= '0;
      end else begin
         lock_state_q      <= lock_state_d;
         lock_idx_q        <= lock_idx_d;
         rr_ptr_q          <= rr_ptr_d;
         msg_valid_q       <= msg_valid_d;
         msg_type_q        <= msg_type_d;
         msg_bus_q         <= msg_bus_d;
         msg_data_q        <= msg_data_d;
         msg_self_perm_q   <= msg_self_perm_d;
         msg_self_addr_q   <= msg_self_addr_d;
         msg_incept_perm_q <= msg_incept_perm_d;
         msg_incept_addr_q <= msg_incept_addr_d;
      end
   end

   assign msg_valid             = msg_valid_q;
   assign msg_type              = msg_type_q;
   assign msg_bus               = msg_bus_q;
   assign msg_data              = msg_data_q;
   assign msg_self_permission   = msg_self_perm_q;
   assign msg_self_address      = msg_self_addr_q;
   assign msg_incept_permission = msg_incept_perm_q;
   assign msg_incept_address    = msg_incept_addr_q;
   assign stream_locked         = (lock_state_q == LOCKED);

endmodule

// File: tb/tb_uarc_receiver_arbiter.sv
// Directed, table-driven bench for uarc_receiver_arbiter: each row drives one cycle,
// checks the combinational acks mid-cycle and the registered message after the edge.
module tb_uarc_receiver_arbiter;

   localparam int BUSES = 32;
   localparam int WIDTH = 32;
   localparam logic [31:0] ALL = 32'hFFFF_FFFF;
   localparam logic [31:0] Z   = 32'h0;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct {
      logic        rst;
      logic [31:0] en, kl, inc, snd, str;
      logic        acc, rdy;
      logic [31:0] ek, ei, es, et;
      logic        ev;
      logic [1:0]  ety;
      logic [4:0]  ebus;
      logic        elk;
   } vec_t;

   logic clk;
   logic reset;
   logic [BUSES-1:0] receiver_enable, receiver_kills, receiver_incepts, receiver_sends, receiver_streams;
   logic [BUSES-1:0] receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks;
   logic [BUSES-1:0][WIDTH-1:0] receiver_datas, receiver_self_permissions, receiver_self_addresses;
   logic [BUSES-1:0][WIDTH-1:0] receiver_incept_permissions, receiver_incept_addresses;
   logic accept, msg_valid, msg_ready, stream_locked;
   logic [1:0] msg_type;
   logic [4:0] msg_bus;
   logic [WIDTH-1:0] msg_data, msg_self_permission, msg_self_address;
   logic [WIDTH-1:0] msg_incept_permission, msg_incept_address;

   uarc_receiver_arbiter dut (
      .clk                         (clk),
      .reset                       (reset),
      .receiver_enable             (receiver_enable),
      .receiver_kills              (receiver_kills),
      .receiver_incepts            (receiver_incepts),
      .receiver_sends              (receiver_sends),
      .receiver_streams            (receiver_streams),
      .receiver_kill_acks          (receiver_kill_acks),
      .receiver_incept_acks        (receiver_incept_acks),
      .receiver_send_acks          (receiver_send_acks),
      .receiver_stream_acks        (receiver_stream_acks),
      .receiver_datas              (receiver_datas),
      .receiver_self_permissions   (receiver_self_permissions),
      .receiver_self_addresses     (receiver_self_addresses),
      .receiver_incept_permissions (receiver_incept_permissions),
      .receiver_incept_addresses   (receiver_incept_addresses),
      .accept                      (accept),
      .msg_valid                   (msg_valid),
      .msg_ready                   (msg_ready),
      .msg_type                    (msg_type),
      .msg_bus                     (msg_bus),
      .msg_data                    (msg_data),
      .msg_self_permission         (msg_self_permission),
      .msg_self_address            (msg_self_address),
      .msg_incept_permission       (msg_incept_permission),
      .msg_incept_address          (msg_incept_address),
      .stream_locked               (stream_locked)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int passed = 0;
   int total  = 0;

   logic [31:0]  data_m [BUSES];
   logic [31:0]  sp_m   [BUSES];
   logic [31:0]  sa_m   [BUSES];
   logic [31:0]  ip_m   [BUSES];
   logic [31:0]  ia_m   [BUSES];
   logic [159:0] exp_pay;
   vec_t         tbl [$];

   function automatic logic [31:0] b(input int i);
      logic [31:0] one;
      one = 32'h1;
      return one << i;
   endfunction

   function automatic vec_t mk(input logic rst, input logic [31:0] en, kl, inc, snd, str,
                               input logic acc, rdy, input logic [31:0] ek, ei, es, et,
                               input logic ev, input logic [1:0] ety, input logic [4:0] ebus,
                               input logic elk);
      vec_t v;
      v.rst = rst; v.en = en; v.kl = kl; v.inc = inc; v.snd = snd; v.str = str;
      v.acc = acc; v.rdy = rdy; v.ek = ek; v.ei = ei; v.es = es; v.et = et;
      v.ev = ev; v.ety = ety; v.ebus = ebus; v.elk = elk;
      return v;
   endfunction

   function automatic logic [159:0] pay_of(input logic [4:0] bus);
      return {data_m[bus], sp_m[bus], sa_m[bus], ip_m[bus], ia_m[bus]};
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else passed++;
   endtask

   task automatic step(input vec_t v);
      reset            = v.rst;
      receiver_enable  = v.en;
      receiver_kills   = v.kl;
      receiver_incepts = v.inc;
      receiver_sends   = v.snd;
      receiver_streams = v.str;
      accept           = v.acc;
      msg_ready        = v.rdy;
      for (int i = 0; i < BUSES; i++) begin
         receiver_datas[i]              = data_m[i];
         receiver_self_permissions[i]   = sp_m[i];
         receiver_self_addresses[i]     = sa_m[i];
         receiver_incept_permissions[i] = ip_m[i];
         receiver_incept_addresses[i]   = ia_m[i];
      end
      @(negedge clk);
      check("acks", {receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks},
            {v.ek, v.ei, v.es, v.et});
      if (v.rst) exp_pay = '0;
      else if ((v.ek | v.ei | v.es | v.et) != 32'h0) exp_pay = pay_of(v.ebus);
      @(posedge clk);
      #1;
      check("msg_valid", msg_valid, v.ev);
      check("msg_type", msg_type, v.ety);
      check("msg_bus", msg_bus, v.ebus);
      check("stream_locked", stream_locked, v.elk);
      check("payload", {msg_data, msg_self_permission, msg_self_address, msg_incept_permission,
                        msg_incept_address}, exp_pay);
   endtask

   initial begin
      for (int i = 0; i < BUSES; i++) begin
         data_m[i] = 32'hDA00_0000 | i;
         sp_m[i]   = 32'h5100_0000 | i;
         sa_m[i]   = 32'h5A00_0000 | i;
         ip_m[i]   = 32'h1100_0000 | i;
         ia_m[i]   = 32'h1A00_0000 | i;
      end
      exp_pay = '0;
      reset = 1'b1;
      receiver_enable = Z; receiver_kills = Z; receiver_incepts = Z;
      receiver_sends = Z; receiver_streams = Z;
      receiver_datas = '0; receiver_self_permissions = '0; receiver_self_addresses = '0;
      receiver_incept_permissions = '0; receiver_incept_addresses = '0;
      accept = 1'b1; msg_ready = 1'b1;
      @(posedge clk);
      #1;

      //        rst en    kl     inc    snd          str acc rdy ek     ei     es      et  ev ety    bus    lk
      tbl.push_back(mk(H, ALL, Z,     Z,     b(2),        Z, H, H, Z,     Z,     Z,      Z, L, 2'd0, 5'd0,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(2)|b(5),   Z, H, H, Z,     Z,     b(2),   Z, H, 2'd2, 5'd2,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(5),        Z, H, H, Z,     Z,     b(5),   Z, H, 2'd2, 5'd5,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     Z,           Z, H, H, Z,     Z,     Z,      Z, L, 2'd2, 5'd5,  L));
      tbl.push_back(mk(L, ALL, b(3),  Z,     b(1),        Z, H, H, b(3),  Z,     Z,      Z, H, 2'd0, 5'd3,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(1),        Z, H, H, Z,     Z,     b(1),   Z, H, 2'd2, 5'd1,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     Z,           Z, H, H, Z,     Z,     Z,      Z, L, 2'd2, 5'd1,  L));
      tbl.push_back(mk(L, ALL, b(7),  b(7),  Z,           Z, L, H, b(7),  Z,     Z,      Z, H, 2'd0, 5'd7,  L));
      tbl.push_back(mk(L, ALL, Z,     b(7),  Z,           Z, L, H, Z,     Z,     Z,      Z, L, 2'd0, 5'd7,  L));
      tbl.push_back(mk(L, ALL, Z,     b(7),  Z,           Z, H, H, Z,     b(7),  Z,      Z, H, 2'd1, 5'd7,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     Z,           Z, H, H, Z,     Z,     Z,      Z, L, 2'd1, 5'd7,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(9)|b(10),  Z, H, H, Z,     Z,     b(9),   Z, H, 2'd2, 5'd9,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(10),       Z, H, L, Z,     Z,     Z,      Z, H, 2'd2, 5'd9,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(10),       Z, H, L, Z,     Z,     Z,      Z, H, 2'd2, 5'd9,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(10),       Z, H, L, Z,     Z,     Z,      Z, H, 2'd2, 5'd9,  L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(10),       Z, H, H, Z,     Z,     b(10),  Z, H, 2'd2, 5'd10, L));
      tbl.push_back(mk(L, ALL, Z,     Z,     Z,           Z, H, H, Z,     Z,     Z,      Z, L, 2'd2, 5'd10, L));
      tbl.push_back(mk(L, ~b(12), b(12), Z,  b(12)|b(13), Z, H, H, Z,     Z,     b(13),  Z, H, 2'd2, 5'd13, L));
      tbl.push_back(mk(L, ~b(12), b(12), Z,  b(12),       Z, H, H, Z,     Z,     Z,      Z, L, 2'd2, 5'd13, L));
      tbl.push_back(mk(L, ALL, Z,     Z,     b(2),        Z, H, H, Z,     Z,     b(2),   Z, H, 2'd2, 5'd2,  L));

      foreach (tbl[i]) step(tbl[i]);

      // Stream on bus 4 with a competing send on bus 0; each word carries new data.
      data_m[4] = 32'hA;
      step(mk(L, ALL, Z, Z, b(0), b(4), H, H, Z, Z, Z, b(4), H, 2'd3, 5'd4, H));
      data_m[4] = 32'hB;
      step(mk(L, ALL, Z, Z, b(0), b(4), H, H, Z, Z, Z, b(4), H, 2'd3, 5'd4, H));
      data_m[4] = 32'hC;
      step(mk(L, ALL, Z, Z, b(0), b(4), H, H, Z, Z, Z, b(4), H, 2'd3, 5'd4, H));
      check("stream_last_data", {96'h0, msg_data}, {96'h0, 32'hC});
      step(mk(L, ALL, Z, Z, b(0), Z,    H, H, Z, Z, Z,    Z,    L, 2'd3, 5'd4, L));
      step(mk(L, ALL, Z, Z, b(0), Z,    H, H, Z, Z, b(0), Z,    H, 2'd2, 5'd0, L));

      // Reset while locked and holding an unconsumed message.
      step(mk(L, ALL, Z, Z, Z,         b(6), H, H, Z, Z, Z,    b(6), H, 2'd3, 5'd6, H));
      step(mk(L, ALL, Z, Z, Z,         b(6), H, L, Z, Z, Z,    Z,    H, 2'd3, 5'd6, H));
      step(mk(H, ALL, Z, Z, b(0),      b(6), H, L, Z, Z, Z,    Z,    L, 2'd0, 5'd0, L));
      step(mk(L, ALL, Z, Z, b(0)|b(3), Z,    H, H, Z, Z, b(0), Z,    H, 2'd2, 5'd0, L));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
